// File: rtl/counter_step_scheduler.sv
// Control front-end for the shift/binary LED counter datapaths: debounces the step, mode and
// auto buttons and sequences one-cycle step/clear strobes, the mode select and the auto timer.
module counter_step_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned AUTO_PERIOD     = 25000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_step_i,
  input  logic       btn_mode_i,
  input  logic       btn_auto_i,
  output logic       step_o,
  output logic       clear_o,
  output logic [1:0] mode_o,
  output logic       auto_en_o
);

  localparam int unsigned BtnStep = 0;
  localparam int unsigned BtnMode = 1;
  localparam int unsigned BtnAuto = 2;

  localparam logic [CNT_W-1:0] DbLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PreLast = CNT_W'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StClear, StStep} state_e;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_auto_i, btn_mode_i, btn_step_i};

  // Per button: 2-flop synchronizer, then a level that only follows after a stable run.
  for (genvar g = 0; g < 3; g++) begin : gen_btn
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DbLast) begin
          level_d = sync2_q;
          press_d = ~sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        level_q <= 1'b1;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[g];
        sync2_q <= sync1_q;
        level_q <= level_d;
        press_q <= press_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press[g] = press_q;
  end

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [1:0]       mode_q, mode_d;
  logic             auto_q, auto_d;
  logic             step_q, step_d;
  logic             clear_q, clear_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic             tick;
  logic             step_req;

  assign tick     = auto_q && (pre_q == PreLast);
  assign step_req = press[BtnStep] | tick;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (press[BtnMode]) begin
          state_d = StClear;
          mode_d  = mode_q + 2'd1;
          // A step arriving with the mode press is served after the clear.
          pend_d  = pend_q | step_req;
        end else if (step_req || pend_q) begin
          state_d = StStep;
        end
      end
      StClear: begin
        state_d = StIdle;
        pend_d  = pend_q | step_req;
      end
      StStep: begin
        state_d = StIdle;
        // Manual presses are queued; auto ticks landing here are dropped.
        pend_d  = press[BtnStep];
      end
      default: state_d = StIdle;
    endcase

    step_d  = (state_d == StStep);
    clear_d = (state_d == StClear);
    auto_d  = auto_q ^ press[BtnAuto];

    if (!auto_q || press[BtnAuto] || (state_d != StIdle) || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      mode_q  <= 2'b00;
      auto_q  <= 1'b0;
      step_q  <= 1'b0;
      clear_q <= 1'b0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      auto_q  <= auto_d;
      step_q  <= step_d;
      clear_q <= clear_d;
      pre_q   <= pre_d;
    end
  end

  assign step_o    = step_q;
  assign clear_o   = clear_q;
  assign mode_o    = mode_q;
  assign auto_en_o = auto_q;

endmodule

// File: tb/tb_counter_step_scheduler.sv
// Scoreboard bench for counter_step_scheduler: a cycle-level reference model queues expected
// strobe/auto events, and a monitor pops and compares whenever the DUT shows one.
module tb_counter_step_scheduler;

  localparam int unsigned D = 4;
  localparam int unsigned P = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn = 3'b111;
  logic       step, clear, auto_en;
  logic [1:0] mode;

  counter_step_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .AUTO_PERIOD    (P),
    .CNT_W          (25)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .btn_step_i(btn[0]),
    .btn_mode_i(btn[1]),
    .btn_auto_i(btn[2]),
    .step_o    (step),
    .clear_o   (clear),
    .mode_o    (mode),
    .auto_en_o (auto_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic step;
    logic clear;
    logic [1:0] mode;
    logic auto_en;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  // Reference model state: outputs are 0 none, 1 step, 2 clear.
  bit  m_hist [3][D+2];
  bit  m_level[3];
  bit  m_press[3];
  bit  m_auto;
  int  m_mode;
  int  m_last;
  bit  m_pend;
  int  m_r;

  int  step_cnt = 0, clear_cnt = 0, last_step_cyc = 0, last_clear_cyc = 0;
  bit  prev_auto = 1'b0, prev_strobe = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < int'(D) + 2; j++) m_hist[b][j] = 1'b1;
      m_level[b] = 1'b1;
      m_press[b] = 1'b0;
    end
    m_auto = 1'b0;
    m_mode = 0;
    m_last = 0;
    m_pend = 1'b0;
    m_r    = cyc;
    exp_q.delete();
  endtask

  // Called once per rising edge k: derives cycle k's outputs from cycle k-1's events.
  task automatic model_step();
    bit   tick, man, req, auto_prev, all_diff;
    int   out;
    ev_t  e;
    auto_prev = m_auto;
    tick = m_auto && ((cyc - 1 - m_r) == int'(P) - 1);
    man  = m_press[0];
    req  = man | tick;
    out  = 0;
    if (m_last == 2) m_pend = m_pend | req;
    else if (m_last == 1) m_pend = man;
    else if (m_press[1]) begin
      out    = 2;
      m_mode = (m_mode + 1) % 4;
      m_pend = m_pend | req;
    end else if (req || m_pend) out = 1;
    if (m_press[2]) m_auto = !m_auto;
    if (!auto_prev || m_press[2] || out != 0 || tick) m_r = cyc;
    m_last = out;
    // A press is D consecutive synchronized lows (raw delayed by 2) against a released level.
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < int'(D) + 1; j++) m_hist[b][j] = m_hist[b][j+1];
      m_hist[b][D+1] = btn[b];
      all_diff = 1'b1;
      for (int j = 0; j < int'(D); j++) if (m_hist[b][j] == m_level[b]) all_diff = 1'b0;
      m_press[b] = 1'b0;
      if (all_diff) begin
        m_level[b] = !m_level[b];
        m_press[b] = !m_level[b];
      end
    end
    if (out != 0 || m_auto != auto_prev) begin
      e.cyc = cyc; e.step = (out == 1); e.clear = (out == 2);
      e.mode = 2'(m_mode); e.auto_en = m_auto;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) model_step();
    end
  endtask

  task automatic monitor_loop();
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_auto   = 1'b0;
        prev_strobe = 1'b0;
      end else begin
        if (exp_q.size() > 0) begin
          n_checks++;
          if (exp_q[0].cyc < cyc) begin
            n_fail++;
            $display("FAIL missed_event: expected event at cycle %0d, still outstanding at cycle %0d",
                     exp_q[0].cyc, cyc);
            e = exp_q.pop_front();
          end
        end
        if (step || clear || auto_en !== prev_auto) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: cycle %0d step=%b clear=%b auto=%b, expected none",
                     cyc, step, clear, auto_en);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.step !== step || e.clear !== clear || e.mode !== mode ||
                e.auto_en !== auto_en) begin
              n_fail++;
              $display("FAIL event: got cyc=%0d step=%b clear=%b mode=%b auto=%b, expected cyc=%0d step=%b clear=%b mode=%b auto=%b",
                       cyc, step, clear, mode, auto_en, e.cyc, e.step, e.clear, e.mode, e.auto_en);
            end
          end
        end
        n_checks++;
        if (int'(mode) != m_mode || auto_en !== m_auto) begin
          n_fail++;
          $display("FAIL state: cycle %0d got mode=%b auto=%b, expected mode=%0d auto=%b",
                   cyc, mode, auto_en, m_mode, m_auto);
        end
        if (step || clear) begin
          n_checks++;
          if ((step && clear) || prev_strobe) begin
            n_fail++;
            $display("FAIL strobe_rule: cycle %0d step=%b clear=%b prev_strobe=%b, expected lone pulse",
                     cyc, step, clear, prev_strobe);
          end
        end
        if (step) begin step_cnt++; last_step_cyc = cyc; end
        if (clear) begin clear_cnt++; last_clear_cyc = cyc; end
        prev_auto   = auto_en;
        prev_strobe = step | clear;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b0;
    cycles(hold);
    btn[b] = 1'b1;
    cycles(10);
  endtask

  int s0, c0, drop, found;

  initial begin
    model_reset();
    fork
      model_loop();
      monitor_loop();
    join_none
    cycles(3);
    check("reset_step", int'(step), 0);
    check("reset_clear", int'(clear), 0);
    check("reset_mode", int'(mode), 0);
    check("reset_auto", int'(auto_en), 0);
    rst_n = 1'b1;
    cycles(5);

    // 1: long step press -> one step, 7 cycles after the button falls
    s0 = step_cnt; c0 = clear_cnt;
    btn[0] = 1'b0; drop = cyc;
    cycles(20);
    btn[0] = 1'b1;
    cycles(10);
    check("t1_step_count", step_cnt - s0, 1);
    check("t1_latency", last_step_cyc - drop, 7);
    check("t1_no_clear", clear_cnt - c0, 0);

    // 2: bounce shorter than the debounce window, then a stable hold
    s0 = step_cnt;
    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b0; cycles(2);
      btn[0] = 1'b1; cycles(2);
    end
    cycles(8);
    check("t2_no_bounce_step", step_cnt - s0, 0);
    press(0, 15);
    check("t2_step_count", step_cnt - s0, 1);

    // 3: four mode presses wrap the mode back to 00
    s0 = step_cnt; c0 = clear_cnt;
    for (int i = 0; i < 4; i++) press(1, 8);
    check("t3_clear_count", clear_cnt - c0, 4);
    check("t3_no_step", step_cnt - s0, 0);
    check("t3_mode_wrapped", int'(mode), 0);

    // 4: auto run, a manual step at a random phase, then auto off
    press(2, 8);
    check("t4_auto_on", int'(auto_en), 1);
    s0 = step_cnt;
    cycles(30);
    check("t4_auto_steps", int'((step_cnt - s0) >= 3), 1);
    cycles($urandom_range(7, 0));
    press(0, 8);
    cycles(20);
    press(2, 8);
    check("t4_auto_off", int'(auto_en), 0);
    s0 = step_cnt;
    cycles(30);
    check("t4_no_more_steps", step_cnt - s0, 0);

    // 5: mode and step together -> clear, then step two cycles later
    s0 = step_cnt; c0 = clear_cnt;
    btn[0] = 1'b0; btn[1] = 1'b0;
    cycles(8);
    btn = 3'b111;
    cycles(12);
    check("t5_clear_count", clear_cnt - c0, 1);
    check("t5_step_count", step_cnt - s0, 1);
    check("t5_step_after_clear", last_step_cyc - last_clear_cyc, 2);
    check("t5_mode", int'(mode), 1);

    // 6: reset during a pending-served step with auto running
    press(2, 8);
    cycles(12);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (m_auto && m_last == 0 && (cyc - m_r) == 2) found = 1;
    end
    check("t6_align", found, 1);
    btn[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (m_last == 1 && m_pend) found = 1;
    end
    check("t6_pending_step", found, 1);
    check("t6_in_step", int'(step), 1);
    #1;
    rst_n = 1'b0;
    btn = 3'b111;
    model_reset();
    #1;
    check("t6_rst_step", int'(step), 0);
    check("t6_rst_clear", int'(clear), 0);
    check("t6_rst_mode", int'(mode), 0);
    check("t6_rst_auto", int'(auto_en), 0);
    cycles(3);
    rst_n = 1'b1;
    s0 = step_cnt;
    cycles(40);
    check("t6_no_step_after_reset", step_cnt - s0, 0);

    // 7: random button activity, glitches and presses alike
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++) if ($urandom_range(5, 0) == 0) btn[b] = ~btn[b];
    end
    btn = 3'b111;
    cycles(20);
    if (m_auto) press(2, 8);
    cycles(30);
    check("queue_drained", exp_q.size(), 0);
    check("final_auto_off", int'(auto_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
